mem_boot_loader: RTL and testbench
==================================

# mem_boot_loader

Synthesizable program-load and run-control block for the SPARC-V8 system. It accepts a stream of instruction/data words and writes them byte-serially into the byte-addressable RAM in a configurable byte order. It holds the CPU in reset during loading and for a programmable number of cycles afterwards, then releases it. While the CPU runs, a watchdog limits run time and a halt input ends the run cleanly.

## Interface
- WORD_BYTES, 4, bytes per loaded word (≥1)
- ADDR_W, 9, RAM byte-address width
- BASE_ADDR, 0, byte address of the first loaded byte
- RESET_HOLD, 2, cycles `cpu_reset` stays high after the last byte is written (≥1)
- WATCHDOG, 100000, maximum run cycles; 0 disables the watchdog
- BIG_ENDIAN, 1, 1: MSB byte at the lowest address; 0: LSB byte at the lowest address

Ports (name, direction, width, meaning):
- Clk  in  1  single clock, rising edge
- RESET_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load; honoured only in IDLE, DONE, TIMEOUT or ERR
- word_in  in  8*WORD_BYTES  word to load
- word_valid  in  1  word_in is valid
- word_last  in  1  qualifies the final word of the load
- word_ready  out  1  loader accepts a word this cycle
- halt  in  1  CPU signals end of program
- ram_addr  out  ADDR_W  RAM byte address
- ram_data  out  8  RAM byte data
- ram_we  out  1  RAM byte write strobe
- cpu_reset  out  1  active-high reset to the control unit
- busy  out  1  high in LOAD, WRITE and HOLD
- running  out  1  high in RUN
- words_loaded  out  ADDR_W  words written since the last start
- done, timeout, overflow  out  1 each  sticky status flags, cleared by start

## Operation
- States: IDLE, LOAD, WRITE, HOLD, RUN, DONE, TIMEOUT, ERR.
- IDLE: on start → LOAD; clear the flags and words_loaded; set the address pointer to BASE_ADDR.
- LOAD: word_ready=1. On word_valid:
  - If pointer + WORD_BYTES − 1 > 2^ADDR_W − 1 → ERR and set overflow. The word is not written.
  - Otherwise latch word_in and word_last, then → WRITE.
- WRITE: emit one byte per cycle for WORD_BYTES cycles with ram_we=1 and ram_addr=pointer. The pointer increments after each byte. Byte k (k=0 first) is word[8*(WORD_BYTES−1−k)+:8] when BIG_ENDIAN=1, else word[8k+:8].
  - After the final byte, words_loaded increments.
  - Next state: HOLD if the latched word_last is set, otherwise LOAD.
- HOLD: count RESET_HOLD cycles, then → RUN.
- RUN: cpu_reset=0 and the run counter increments each cycle.
  - halt=1 → DONE.
  - Otherwise, run counter == WATCHDOG−1 (with WATCHDOG≠0) → TIMEOUT.
  - If halt and the watchdog expire in the same cycle, halt wins.
- DONE, TIMEOUT, ERR: cpu_reset=1; the flags hold; start → LOAD.
- start is ignored in LOAD, WRITE, HOLD and RUN.
- cpu_reset=1 in every state except RUN.

## Timing
- Reset values: state IDLE, cpu_reset=1, ram_we=0, ram_addr=BASE_ADDR, ram_data=0, word_ready=0, busy=0, running=0, words_loaded=0, all flags 0.
- RESET_n asserted mid-operation aborts immediately. Bytes already written remain in RAM.
- All outputs are registered except word_ready, which is a decode of state.
- Per-word cost: 1 accept cycle plus WORD_BYTES write cycles.
- First ram_we: the cycle after the first word handshake.
- cpu_reset falls exactly RESET_HOLD cycles after the final ram_we cycle.
- done and timeout rise one cycle after the triggering condition.

## Structure
- Package mem_boot_loader_pkg holds the state enum and the default parameter constants.
- The sub-module word_byte_serializer (parameters WORD_BYTES, BIG_ENDIAN) is the natural split. It takes a latched word and a load pulse and emits byte plus strobe, with a last-byte indication.
- The top level holds the FSM, address pointer, word counter, hold counter and run counter.

## Test plan
- WORD_BYTES=4, BIG_ENDIAN=1, word 0x8E01A005 with word_last=1 → bytes 8E,01,A0,05 written to addresses 0..3. cpu_reset falls 2 cycles after the last write. words_loaded=1.
- BIG_ENDIAN=0, two words 0x11223344 and 0x55667788 → address 0..7 receives 44,33,22,11,88,77,66,55. word_ready is low during each WRITE.
- ADDR_W=4, five words → the fifth word (needing 16..19) is not written, overflow=1, state ERR, words_loaded=4, cpu_reset=1.
- WATCHDOG=10, halt never asserted → timeout=1 exactly 10 RUN cycles after cpu_reset falls, then cpu_reset=1. With halt asserted on cycle 9 → done=1, timeout=0.
- RESET_n pulsed low in the middle of a WRITE → all outputs return to reset values asynchronously. A subsequent start reloads from BASE_ADDR.
- start pulsed during RUN → ignored. start in DONE → flags cleared and a new load begins.

Source files
------------

// File: rtl/mem_boot_loader_pkg.sv
// mem_boot_loader_pkg: state encoding, default parameters and state-class helpers for the boot loader
package mem_boot_loader_pkg;
   localparam int DEF_WORD_BYTES = 4;
   localparam int DEF_ADDR_W     = 9;
   localparam int DEF_BASE_ADDR  = 0;
   localparam int DEF_RESET_HOLD = 2;
   localparam int DEF_WATCHDOG   = 100000;
   localparam bit DEF_BIG_ENDIAN = 1'b1;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_WRITE   = 3'd2;
   localparam logic [2:0] S_HOLD    = 3'd3;
   localparam logic [2:0] S_RUN     = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
   localparam logic [2:0] S_TIMEOUT = 3'd6;
   localparam logic [2:0] S_ERR     = 3'd7;
   function automatic logic is_busy(input logic [2:0] s);
      return s == S_LOAD || s == S_WRITE || s == S_HOLD;
   endfunction
   function automatic logic is_rest(input logic [2:0] s);
      return s == S_IDLE || s == S_DONE || s == S_TIMEOUT || s == S_ERR;
   endfunction
endpackage

// File: rtl/mem_boot_loader_word_byte_serializer.sv
// word_byte_serializer: turns a latched word into WORD_BYTES registered byte strobes in the chosen byte order
module word_byte_serializer #(
   parameter int WORD_BYTES = 4,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [8*WORD_BYTES-1:0] word,
   output logic [7:0]              data,
   output logic                    strobe,
   output logic                    last
);
   localparam int W  = 8 * WORD_BYTES;
   localparam int CW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
   logic [W-1:0]  sh;
   logic [CW-1:0] cnt;
   logic [7:0]    first;
   assign first = BIG_ENDIAN ? word[W-1 -: 8] : word[7:0];
   assign last  = strobe && cnt == CW'(WORD_BYTES - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh     <= '0;
         cnt    <= '0;
         data   <= '0;
         strobe <= 1'b0;
      end else if (load) begin
         sh     <= BIG_ENDIAN ? word << 8 : word >> 8;
         data   <= first;
         strobe <= 1'b1;
         cnt    <= '0;
      end else if (strobe) begin
         data   <= last ? data : (BIG_ENDIAN ? sh[W-1 -: 8] : sh[7:0]);
         sh     <= BIG_ENDIAN ? sh << 8 : sh >> 8;
         strobe <= !last;
         cnt    <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: loads words byte-serially into RAM, holds the CPU in reset, then supervises the run
module mem_boot_loader
   import mem_boot_loader_pkg::*;
#(
   parameter int WORD_BYTES = DEF_WORD_BYTES,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int BASE_ADDR  = DEF_BASE_ADDR,
   parameter int RESET_HOLD = DEF_RESET_HOLD,
   parameter int WATCHDOG   = DEF_WATCHDOG,
   parameter bit BIG_ENDIAN = DEF_BIG_ENDIAN
) (
   input  logic                    Clk,
   input  logic                    RESET_n,
   input  logic                    start,
   input  logic [8*WORD_BYTES-1:0] word_in,
   input  logic                    word_valid,
   input  logic                    word_last,
   output logic                    word_ready,
   input  logic                    halt,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [7:0]              ram_data,
   output logic                    ram_we,
   output logic                    cpu_reset,
   output logic                    busy,
   output logic                    running,
   output logic [ADDR_W-1:0]       words_loaded,
   output logic                    done,
   output logic                    timeout,
   output logic                    overflow
);
   logic [2:0]      state, nxt;
   logic [ADDR_W:0] ptr;
   logic [31:0]     hold_cnt, run_cnt;
   logic            last_q, accept, ovf, ser_last, wd_hit, restart;
   assign word_ready = state == S_LOAD;
   assign accept     = word_ready && word_valid;
   // pointer carries one extra bit so a full RAM is seen as full rather than wrapping to zero
   assign ovf        = ({1'b0, ptr} + (ADDR_W+2)'(WORD_BYTES - 1)) > (ADDR_W+2)'((1 << ADDR_W) - 1);
   assign wd_hit     = WATCHDOG != 0 && run_cnt == 32'(WATCHDOG - 1);
   assign restart    = start && is_rest(state);
   assign ram_addr   = ptr[ADDR_W-1:0];
   word_byte_serializer #(
      .WORD_BYTES(WORD_BYTES),
      .BIG_ENDIAN(BIG_ENDIAN)
   ) u_ser (
      .clk   (Clk),
      .rst_n (RESET_n),
      .load  (accept && !ovf),
      .word  (word_in),
      .data  (ram_data),
      .strobe(ram_we),
      .last  (ser_last)
   );
   always_comb begin
      nxt = state;
      case (state)
         S_LOAD:  nxt = !word_valid ? S_LOAD : ovf ? S_ERR : S_WRITE;
         S_WRITE: nxt = !ser_last ? S_WRITE : last_q ? S_HOLD : S_LOAD;
         S_HOLD:  nxt = hold_cnt == 32'(RESET_HOLD - 1) ? S_RUN : S_HOLD;
         S_RUN:   nxt = halt ? S_DONE : wd_hit ? S_TIMEOUT : S_RUN;
         default: nxt = restart ? S_LOAD : state;
      endcase
   end
   always_ff @(posedge Clk or negedge RESET_n) begin
      if (!RESET_n) begin
         state        <= S_IDLE;
         ptr          <= (ADDR_W+1)'(BASE_ADDR);
         last_q       <= 1'b0;
         hold_cnt     <= '0;
         run_cnt      <= '0;
         words_loaded <= '0;
         cpu_reset    <= 1'b1;
         busy         <= 1'b0;
         running      <= 1'b0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         state     <= nxt;
         cpu_reset <= nxt != S_RUN;
         busy      <= is_busy(nxt);
         running   <= nxt == S_RUN;
         hold_cnt  <= state == S_HOLD ? hold_cnt + 32'd1 : '0;
         run_cnt   <= state == S_RUN ? run_cnt + 32'd1 : '0;
         if (accept) last_q <= word_last;
         if (accept && ovf) overflow <= 1'b1;
         if (ram_we) ptr <= ptr + 1'b1;
         if (ser_last) words_loaded <= words_loaded + 1'b1;
         if (state == S_RUN && nxt == S_DONE) done <= 1'b1;
         if (state == S_RUN && nxt == S_TIMEOUT) timeout <= 1'b1;
         if (restart) begin
            ptr          <= (ADDR_W+1)'(BASE_ADDR);
            words_loaded <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: directed scenarios on a big-endian and a little-endian loader sharing one stimulus stream
module tb_mem_boot_loader;
   logic        Clk = 1'b0, RESET_n = 1'b0, start = 1'b0, word_valid = 1'b0, word_last = 1'b0, halt = 1'b0;
   logic [31:0] word_in = '0;
   logic        word_ready, ram_we, cpu_reset, busy, running, done, timeout, overflow;
   logic [3:0]  ram_addr, words_loaded;
   logic [7:0]  ram_data;
   logic        wr_le, we_le, cr_le, busy_le, run_le, done_le, to_le, ovf_le;
   logic [3:0]  addr_le, wl_le;
   logic [7:0]  data_le;
   logic [7:0]  mem_be [16];
   logic [7:0]  mem_le [16];
   int cyc = 0, last_we = 0, fall_cyc = 0, to_cyc = 0, writes = 0, overlap = 0, diverge = 0;
   logic prev_cr = 1'b1, prev_to = 1'b0;
   int passed = 0, total = 0;

   always #5 Clk = ~Clk;

   mem_boot_loader #(.WORD_BYTES(4), .ADDR_W(4), .BASE_ADDR(0), .RESET_HOLD(2), .WATCHDOG(10), .BIG_ENDIAN(1)) u_dut (
      .Clk(Clk), .RESET_n(RESET_n), .start(start), .word_in(word_in), .word_valid(word_valid),
      .word_last(word_last), .word_ready(word_ready), .halt(halt), .ram_addr(ram_addr), .ram_data(ram_data),
      .ram_we(ram_we), .cpu_reset(cpu_reset), .busy(busy), .running(running), .words_loaded(words_loaded),
      .done(done), .timeout(timeout), .overflow(overflow));

   mem_boot_loader #(.WORD_BYTES(4), .ADDR_W(4), .BASE_ADDR(0), .RESET_HOLD(2), .WATCHDOG(10), .BIG_ENDIAN(0)) u_le (
      .Clk(Clk), .RESET_n(RESET_n), .start(start), .word_in(word_in), .word_valid(word_valid),
      .word_last(word_last), .word_ready(wr_le), .halt(halt), .ram_addr(addr_le), .ram_data(data_le),
      .ram_we(we_le), .cpu_reset(cr_le), .busy(busy_le), .running(run_le), .words_loaded(wl_le),
      .done(done_le), .timeout(to_le), .overflow(ovf_le));

   // RAM models and event timestamps, sampled mid-cycle
   always @(negedge Clk) begin
      cyc = cyc + 1;
      if (ram_we) begin
         mem_be[ram_addr] = ram_data;
         last_we = cyc;
         writes = writes + 1;
         if (word_ready) overlap = overlap + 1;
      end
      if (we_le) mem_le[addr_le] = data_le;
      if (prev_cr && !cpu_reset) fall_cyc = cyc;
      if (!prev_to && timeout) to_cyc = cyc;
      prev_cr = cpu_reset;
      prev_to = timeout;
      if ({word_ready, ram_addr, ram_we, cpu_reset, busy, running, words_loaded, done, timeout, overflow} !==
          {wr_le, addr_le, we_le, cr_le, busy_le, run_le, wl_le, done_le, to_le, ovf_le})
         diverge = diverge + 1;
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge Clk); #1 start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic l);
      int n = 0;
      word_in = w; word_last = l; word_valid = 1'b1;
      @(negedge Clk);
      while (!word_ready && n < 50) begin @(negedge Clk); n++; end
      total++; if (!word_ready) $display("FAIL handshake: word_ready got 0 want 1"); else passed++;
      @(posedge Clk); #1 word_valid = 1'b0;
   endtask

   task automatic wait_run();
      int n = 0;
      while (cpu_reset && n < 100) begin @(negedge Clk); n++; end
      total++; if (cpu_reset !== 1'b0) $display("FAIL run_entry: cpu_reset got %b want 0", cpu_reset); else passed++;
   endtask

   task automatic test_reset();
      #12;
      total++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); else passed++;
      total++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", ram_we); else passed++;
      total++; if (ram_addr !== 4'h0) $display("FAIL rst_ram_addr: got %0h want 0", ram_addr); else passed++;
      total++; if (ram_data !== 8'h00) $display("FAIL rst_ram_data: got %0h want 0", ram_data); else passed++;
      total++; if ({word_ready, busy, running} !== 3'b000) $display("FAIL rst_ctl: got %b want 000", {word_ready, busy, running}); else passed++;
      total++; if (words_loaded !== 4'h0) $display("FAIL rst_words: got %0d want 0", words_loaded); else passed++;
      total++; if ({done, timeout, overflow} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {done, timeout, overflow}); else passed++;
      #1 RESET_n = 1'b1;
      @(posedge Clk); #1;
   endtask

   task automatic test_load_run_halt();
      logic [7:0] exp_be [4] = '{8'h8E, 8'h01, 8'hA0, 8'h05};
      pulse_start();
      send_word(32'h8E01A005, 1'b1);
      wait_run();
      @(posedge Clk); #1;
      total++; if (fall_cyc - last_we - 1 != 2) $display("FAIL hold_cycles: got %0d want 2", fall_cyc - last_we - 1); else passed++;
      pulse_start();
      @(negedge Clk);
      total++; if ({running, cpu_reset, busy} !== 3'b100) $display("FAIL start_in_run: got %b want 100", {running, cpu_reset, busy}); else passed++;
      @(posedge Clk); #1 halt = 1'b1;
      @(posedge Clk); #1 halt = 1'b0;
      @(negedge Clk);
      total++; if ({done, timeout} !== 2'b10) $display("FAIL halt_flags: got %b want 10", {done, timeout}); else passed++;
      total++; if ({cpu_reset, running} !== 2'b10) $display("FAIL halt_ctl: got %b want 10", {cpu_reset, running}); else passed++;
      total++; if (words_loaded !== 4'd1) $display("FAIL words_one: got %0d want 1", words_loaded); else passed++;
      for (int i = 0; i < 4; i++) begin
         total++; if (mem_be[i] !== exp_be[i]) $display("FAIL be_byte%0d: got %0h want %0h", i, mem_be[i], exp_be[i]); else passed++;
         total++; if (mem_le[i] !== exp_be[3-i]) $display("FAIL le_byte%0d: got %0h want %0h", i, mem_le[i], exp_be[3-i]); else passed++;
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_two_words_timeout();
      logic [7:0] exp_le [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
      int n = 0;
      pulse_start();
      @(negedge Clk);
      total++; if ({done, busy, word_ready} !== 3'b011) $display("FAIL restart_done: got %b want 011", {done, busy, word_ready}); else passed++;
      @(posedge Clk); #1;
      send_word(32'h11223344, 1'b0);
      send_word(32'h55667788, 1'b1);
      wait_run();
      @(posedge Clk); #1;
      while (!timeout && n < 50) begin @(negedge Clk); n++; end
      @(posedge Clk); #1;
      total++; if (to_cyc - fall_cyc != 10) $display("FAIL wd_cycles: got %0d want 10", to_cyc - fall_cyc); else passed++;
      total++; if ({timeout, done, cpu_reset, running} !== 4'b1010) $display("FAIL wd_state: got %b want 1010", {timeout, done, cpu_reset, running}); else passed++;
      total++; if (words_loaded !== 4'd2) $display("FAIL words_two: got %0d want 2", words_loaded); else passed++;
      total++; if (overlap != 0) $display("FAIL ready_in_write: got %0d want 0", overlap); else passed++;
      for (int i = 0; i < 8; i++) begin
         total++; if (mem_le[i] !== exp_le[i]) $display("FAIL le2_byte%0d: got %0h want %0h", i, mem_le[i], exp_le[i]); else passed++;
      end
      total++; if ({mem_be[0], mem_be[7]} !== 16'h1188) $display("FAIL be2_bytes: got %0h want 1188", {mem_be[0], mem_be[7]}); else passed++;
   endtask

   task automatic test_halt_with_watchdog();
      pulse_start();
      send_word(32'h01020304, 1'b1);
      wait_run();
      repeat (9) @(posedge Clk);
      #1 halt = 1'b1;
      @(posedge Clk); #1 halt = 1'b0;
      @(negedge Clk);
      total++; if ({done, timeout} !== 2'b10) $display("FAIL halt_c9: got %b want 10", {done, timeout}); else passed++;
      @(posedge Clk); #1;
   endtask

   task automatic test_overflow();
      int w0;
      pulse_start();
      w0 = writes;
      for (int i = 0; i < 5; i++) send_word({8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)}, 1'b0);
      @(negedge Clk);
      total++; if ({overflow, word_ready, busy, cpu_reset} !== 4'b1001) $display("FAIL ovf_state: got %b want 1001", {overflow, word_ready, busy, cpu_reset}); else passed++;
      repeat (3) @(negedge Clk);
      total++; if (writes - w0 != 16) $display("FAIL ovf_writes: got %0d want 16", writes - w0); else passed++;
      total++; if (words_loaded !== 4'd4) $display("FAIL ovf_words: got %0d want 4", words_loaded); else passed++;
      total++; if ({mem_be[0], mem_be[12], mem_be[15]} !== 24'hA0A3D3) $display("FAIL ovf_mem: got %0h want a0a3d3", {mem_be[0], mem_be[12], mem_be[15]}); else passed++;
      total++; if (mem_le[12] !== 8'hD3) $display("FAIL ovf_le: got %0h want d3", mem_le[12]); else passed++;
      @(posedge Clk); #1;
   endtask

   task automatic test_async_reset();
      pulse_start();
      send_word(32'h5A6B7C8D, 1'b0);
      @(posedge Clk); #2 RESET_n = 1'b0;
      #1;
      total++; if ({ram_we, busy, cpu_reset, word_ready} !== 4'b0010) $display("FAIL arst_ctl: got %b want 0010", {ram_we, busy, cpu_reset, word_ready}); else passed++;
      total++; if ({ram_addr, ram_data} !== 12'h000) $display("FAIL arst_bus: got %0h want 0", {ram_addr, ram_data}); else passed++;
      total++; if (mem_be[0] !== 8'h5A) $display("FAIL arst_kept: got %0h want 5a", mem_be[0]); else passed++;
      #3 RESET_n = 1'b1;
      @(posedge Clk); #1;
      pulse_start();
      send_word(32'hCAFEF00D, 1'b1);
      wait_run();
      @(posedge Clk); #1;
      total++; if ({mem_be[0], mem_be[3]} !== 16'hCA0D) $display("FAIL reload_mem: got %0h want ca0d", {mem_be[0], mem_be[3]}); else passed++;
      total++; if ({words_loaded, running} !== 5'b00011) $display("FAIL reload_state: got %b want 00011", {words_loaded, running}); else passed++;
      halt = 1'b1;
      @(posedge Clk); #1 halt = 1'b0;
      @(negedge Clk);
      total++; if (done !== 1'b1) $display("FAIL reload_done: got %b want 1", done); else passed++;
      total++; if (diverge != 0) $display("FAIL endian_ctl_diverge: got %0d want 0", diverge); else passed++;
   endtask

   initial begin
      test_reset();
      test_load_run_halt();
      test_two_words_timeout();
      test_halt_with_watchdog();
      test_overflow();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
